// File: rtl/acq_controller.sv
// acq_controller: acquisition sequencer for the oscilloscope capture path.
// Generates the sample-rate strobe, arms the trigger datapath and walks each
// acquisition through ARMED -> CAPTURE -> PRESENT -> HOLDOFF.
// Optional feature macro: ACQ_CTRL_AUTO_EN builds the AUTO-mode strobe timeout
// and the force_trig pulse; without it mode 1 runs as NORMAL.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | not acquiring; waits for run (and single_req in SINGLE mode)
// ARMED   | datapath may detect a trigger; AUTO timeout counting strobes
// CAPTURE | trigger seen, datapath filling its record
// PRESENT | frame offered to the display until frame_ack
// HOLDOFF | dead time after a presented frame before re-arming
module acq_controller #(
    parameter int DIV_W        = 12,
    parameter int HOLDOFF_W    = 16,
    parameter int AUTO_TIMEOUT = 2048
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_mode,
    input  logic                 i_run,
    input  logic                 i_single_req,
    input  logic [DIV_W-1:0]     i_div_sel,
    input  logic [HOLDOFF_W-1:0] i_holdoff,
    input  logic                 i_trig_seen,
    input  logic                 i_capture_done,
    input  logic                 i_frame_ack,
    output logic                 o_sample_en,
    output logic                 o_arm,
    output logic                 o_force_trig,
    output logic                 o_frame_valid,
    output logic                 o_busy,
    output logic [2:0]           o_state,
    output logic [15:0]          o_frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    state_t               w_post;
    logic [DIV_W-1:0]     r_pre;
    logic                 r_sample_en;
    logic [HOLDOFF_W-1:0] r_ho;
    logic [15:0]          r_frame_cnt;
    logic                 r_arm;
    logic                 r_force;
    logic                 r_frame_valid;
    logic                 r_busy;
    logic                 r_single;
    logic                 w_mode_single;
    logic                 w_force;
    logic                 w_frame_done;
    logic                 w_to_hit;

    assign w_mode_single = (i_mode == 2'd2);

    // r_single is frozen once the frame leaves ARMED, so a mode change made
    // mid-frame only affects where the frame ends up at its next ARMED entry.
    assign w_post = r_single ? ST_IDLE : ST_ARMED;

`ifdef ACQ_CTRL_AUTO_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] r_to;
    logic [TO_W-1:0] w_to_inc;

    assign w_to_inc = r_to + 1'b1;
    assign w_to_hit = (r_state == ST_ARMED) && (i_mode == 2'd1) && r_sample_en &&
                      (w_to_inc >= TO_W'(AUTO_TIMEOUT));

    // Strobe counter for the AUTO timeout; held at zero outside ARMED so every entry starts fresh.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to <= '0;
        end else if (r_state != ST_ARMED) begin
            r_to <= '0;
        end else if (r_sample_en) begin
            r_to <= w_to_inc;
        end
    end
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(AUTO_TIMEOUT);
    assign w_to_hit         = 1'b0;
`endif

    // Free-running sample-rate prescaler; the >= compare lets a lowered div_sel take effect at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre       <= '0;
            r_sample_en <= 1'b0;
        end else if (r_pre >= i_div_sel) begin
            r_pre       <= '0;
            r_sample_en <= 1'b1;
        end else begin
            r_pre       <= r_pre + 1'b1;
            r_sample_en <= 1'b0;
        end
    end

    // Next-state selection; run low outranks every datapath event except the PRESENT handshake.
    always_comb begin
        w_next       = r_state;
        w_force      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_run && (!w_mode_single || i_single_req)) begin
                    w_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!i_run) begin
                    w_next = ST_IDLE;
                end else if (i_trig_seen) begin
                    w_next = ST_CAPTURE;
                end else if (w_to_hit) begin
                    w_next  = ST_CAPTURE;
                    w_force = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (!i_run) begin
                    w_next = ST_IDLE;
                end else if (i_capture_done) begin
                    w_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_frame_ack) begin
                    w_frame_done = 1'b1;
                    if (!i_run) begin
                        w_next = ST_IDLE;
                    end else if (i_holdoff == '0) begin
                        w_next = w_post;
                    end else begin
                        w_next = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (!i_run) begin
                    w_next = ST_IDLE;
                end else if (r_ho >= i_holdoff) begin
                    w_next = w_post;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_arm         <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_force       <= 1'b0;
            r_frame_cnt   <= '0;
            r_ho          <= '0;
            r_single      <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_arm         <= (w_next == ST_ARMED) || (w_next == ST_CAPTURE);
            r_busy        <= (w_next != ST_IDLE);
            r_frame_valid <= (w_next == ST_PRESENT);
            r_force       <= w_force;
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            // First HOLDOFF cycle sees 1, so a holdoff of N spends exactly N cycles there.
            if (r_state == ST_HOLDOFF) begin
                r_ho <= r_ho + 1'b1;
            end else begin
                r_ho <= HOLDOFF_W'(1);
            end
            if ((r_state == ST_IDLE) || (r_state == ST_ARMED)) begin
                r_single <= w_mode_single;
            end
        end
    end

    assign o_sample_en   = r_sample_en;
    assign o_arm         = r_arm;
    assign o_force_trig  = r_force;
    assign o_frame_valid = r_frame_valid;
    assign o_busy        = r_busy;
    assign o_state       = r_state;
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_acq_controller.sv
// tb_acq_controller: scoreboard bench for acq_controller.
// Stimulus tasks predict each state change (state, cycle, frame count,
// force_trig) and queue it; a negedge monitor pops and compares whenever the
// DUT changes state, and also checks the output decode every cycle.
module tb_acq_controller;

    localparam int DIV_W     = 12;
    localparam int HOLDOFF_W = 16;
    localparam int AUTO_TO   = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic                 run = 1'b0;
    logic                 single_req = 1'b0;
    logic [DIV_W-1:0]     div_sel = 12'd3;
    logic [HOLDOFF_W-1:0] holdoff = 16'd0;
    logic                 trig_seen = 1'b0;
    logic                 capture_done = 1'b0;
    logic                 frame_ack = 1'b0;
    logic                 sample_en;
    logic                 arm;
    logic                 force_trig;
    logic                 frame_valid;
    logic                 busy;
    logic [2:0]           state;
    logic [15:0]          frame_cnt;

    acq_controller #(
        .DIV_W(DIV_W),
        .HOLDOFF_W(HOLDOFF_W),
        .AUTO_TIMEOUT(AUTO_TO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_mode(mode),
        .i_run(run),
        .i_single_req(single_req),
        .i_div_sel(div_sel),
        .i_holdoff(holdoff),
        .i_trig_seen(trig_seen),
        .i_capture_done(capture_done),
        .i_frame_ack(frame_ack),
        .o_sample_en(sample_en),
        .o_arm(arm),
        .o_force_trig(force_trig),
        .o_frame_valid(frame_valid),
        .o_busy(busy),
        .o_state(state),
        .o_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  st;
        int          at;
        logic [15:0] fc;
        logic        frc;
    } ev_t;

    ev_t         expq[$];
    ev_t         mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_frames = 16'd0;
    bit          mon_en = 1'b0;
    logic [2:0]  prev_state = 3'd0;
    int          pre_mode = 0;
    int          pre_period = 0;
    int          last_strobe = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_state(input logic [2:0] st, input int at, input logic frc);
        ev_t e;
        e.st  = st;
        e.at  = at;
        e.fc  = m_frames;
        e.frc = frc;
        expq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk_all_zero(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_arm"}, 32'(arm), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_valid"}, 32'(frame_valid), 0);
        check({tag, "_force_trig"}, 32'(force_trig), 0);
        check({tag, "_sample_en"}, 32'(sample_en), 0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    task automatic go_armed();
        run = 1'b1;
        expect_state(S_ARMED, cyc + 1, 1'b0);
        step();
    endtask

    task automatic go_idle();
        run = 1'b0;
        expect_state(S_IDLE, cyc + 1, 1'b0);
        step();
    endtask

    task automatic trig_now();
        trig_seen = 1'b1;
        expect_state(S_CAPTURE, cyc + 1, 1'b0);
        step();
        trig_seen = 1'b0;
    endtask

    // From CAPTURE: capture_done after cap_d cycles, ack after ack_d cycles of PRESENT,
    // then ho holdoff cycles before landing in post.
    task automatic finish_frame(input int cap_d, input int ack_d, input int ho, input logic [2:0] post);
        int t;
        holdoff = HOLDOFF_W'(ho);
        repeat (cap_d) step();
        capture_done = 1'b1;
        expect_state(S_PRESENT, cyc + 1, 1'b0);
        step();
        capture_done = 1'b0;
        repeat (ack_d) step();
        frame_ack = 1'b1;
        m_frames++;
        t = cyc;
        if (ho == 0) begin
            expect_state(post, t + 1, 1'b0);
        end else begin
            expect_state(S_HOLDOFF, t + 1, 1'b0);
            expect_state(post, t + 1 + ho, 1'b0);
        end
        step();
        frame_ack = 1'b0;
        wait_until(t + 1 + ho);
    endtask

    // Scoreboard monitor: output decode every cycle, queued event on every state change.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("arm_decode", 32'(arm), 32'((state == S_ARMED) || (state == S_CAPTURE)));
            check("busy_decode", 32'(busy), 32'(state != S_IDLE));
            check("frame_valid_decode", 32'(frame_valid), 32'(state == S_PRESENT));
            if (state != prev_state) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_state: got %0d from %0d, expected no change (cycle %0d)",
                             state, prev_state, cyc);
                end else begin
                    mon_e = expq.pop_front();
                    check("evt_state", 32'(state), 32'(mon_e.st));
                    check("evt_cycle", 32'(cyc), 32'(mon_e.at));
                    check("evt_frame_cnt", 32'(frame_cnt), 32'(mon_e.fc));
                    check("evt_force_trig", 32'(force_trig), 32'(mon_e.frc));
                end
            end else begin
                check("force_quiet", 32'(force_trig), 0);
                if ((expq.size() > 0) && (expq[0].at <= cyc)) begin
                    mon_e = expq.pop_front();
                    n_checks++;
                    n_errors++;
                    $display("FAIL late_state: got %0d, expected %0d at cycle %0d (now %0d)",
                             state, mon_e.st, mon_e.at, cyc);
                end
            end
            prev_state = state;
        end
    end

    // Prescaler monitor: exact period (mode 1) or bounded gap of 4 (mode 2).
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_en) begin
                if ((pre_mode == 1) && (last_strobe >= 0)) begin
                    check("strobe_period", 32'(cyc - last_strobe), 32'(pre_period));
                end else if ((pre_mode == 2) && (last_strobe >= 0)) begin
                    check("strobe_gap_le4", 32'((cyc - last_strobe) <= 4), 1);
                end
                last_strobe = cyc;
            end else if ((pre_mode != 0) && (cyc - last_strobe > 16)) begin
                n_checks++;
                n_errors++;
                $display("FAIL strobe_missing: got no strobe for %0d cycles, expected one (cycle %0d)",
                         cyc - last_strobe, cyc);
                last_strobe = cyc;
            end
        end
    end

    initial begin
        int a;
        int ho;
        int dv;

        // Reset values
        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Prescaler: div_sel=3, then random dividers, then switch to 0
        repeat (20) step();
        pre_period = 4;
        pre_mode = 1;
        repeat (30) step();
        for (int i = 0; i < 3; i++) begin
            pre_mode = 0;
            dv = $urandom_range(1, 7);
            div_sel = DIV_W'(dv);
            repeat (20) step();
            pre_period = dv + 1;
            pre_mode = 1;
            repeat (3 * (dv + 1) + 2) step();
        end
        pre_mode = 0;
        div_sel = 12'd3;
        repeat (20) step();
        pre_mode = 2;
        div_sel = 12'd0;
        repeat (6) step();
        pre_period = 1;
        pre_mode = 1;
        repeat (10) step();
        pre_mode = 0;

        // NORMAL: the reference frame, then randomized frames
        mode = 2'd0;
        go_armed();
        repeat (2) step();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        trig_now();
        finish_frame(3, 2, 10, S_ARMED);
        for (int i = 0; i < 6; i++) begin
            mode = ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0;
            ho = $urandom_range(0, 12);
            repeat ($urandom_range(0, 4)) step();
            if ($urandom_range(0, 1) != 0) begin
                frame_ack = 1'b1;
                step();
                frame_ack = 1'b0;
            end
            trig_now();
            finish_frame($urandom_range(0, 4), $urandom_range(0, 4), ho, S_ARMED);
        end

        // Abort in ARMED
        repeat (3) step();
        go_idle();
        repeat (4) step();

        // AUTO: no trigger, then trigger on the timeout strobe
        mode = 2'd1;
        go_armed();
        a = cyc;
`ifdef ACQ_CTRL_AUTO_EN
        expect_state(S_CAPTURE, a + AUTO_TO, 1'b1);
`endif
        wait_until(a + AUTO_TO + 4);
        go_idle();
        repeat (3) step();
        go_armed();
        a = cyc;
        wait_until(a + AUTO_TO - 1);
        trig_now();
        finish_frame(1, 1, 0, S_ARMED);
        repeat (2) step();
        go_idle();
        repeat (3) step();

        // SINGLE: needs single_req, ignores it mid-frame, returns to IDLE
        mode = 2'd2;
        run = 1'b1;
        repeat (5) step();
        single_req = 1'b1;
        expect_state(S_ARMED, cyc + 1, 1'b0);
        step();
        single_req = 1'b0;
        repeat (2) step();
        trig_now();
        single_req = 1'b1;
        step();
        single_req = 1'b0;
        finish_frame(2, 1, 3, S_IDLE);
        repeat (6) step();
        single_req = 1'b1;
        expect_state(S_ARMED, cyc + 1, 1'b0);
        step();
        single_req = 1'b0;
        trig_now();
        finish_frame(0, 0, 0, S_IDLE);
        run = 1'b0;
        step();
        mode = 2'd0;
        repeat (3) step();

        // run low together with capture_done: abort wins
        go_armed();
        trig_now();
        step();
        run = 1'b0;
        capture_done = 1'b1;
        expect_state(S_IDLE, cyc + 1, 1'b0);
        step();
        capture_done = 1'b0;
        repeat (3) step();

        // run low in PRESENT: handshake completes, then IDLE despite holdoff
        holdoff = 16'd5;
        go_armed();
        trig_now();
        capture_done = 1'b1;
        expect_state(S_PRESENT, cyc + 1, 1'b0);
        step();
        capture_done = 1'b0;
        run = 1'b0;
        repeat (3) step();
        frame_ack = 1'b1;
        m_frames++;
        expect_state(S_IDLE, cyc + 1, 1'b0);
        step();
        frame_ack = 1'b0;
        repeat (3) step();

        // Asynchronous reset mid-CAPTURE, then restart
        go_armed();
        trig_now();
        repeat (2) step();
        @(negedge clk);
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk_all_zero("async_reset");
        expq.delete();
        m_frames = 16'd0;
        prev_state = S_IDLE;
        step();
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();
        go_armed();
        trig_now();
        finish_frame(1, 2, 2, S_ARMED);
        go_idle();
        repeat (5) step();

        check("scoreboard_empty", 32'(expq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acq_controller.md
# acq_controller

Acquisition sequencer for the oscilloscope capture path. Generates the sample-rate strobe, arms the level-trigger datapath, and steps each acquisition through arm, capture, present and holdoff. Supports NORMAL, AUTO and SINGLE run modes, and handshakes finished frames to the display side. It sits between the user control registers and the trigger/capture datapath, and replaces the datapath's internal free-running rate counter.

## Interface
- DIV_W, 12: width of sample-rate divider.
- HOLDOFF_W, 16: width of holdoff counter.
- AUTO_TIMEOUT, 2048: sample strobes without a trigger before AUTO mode forces a capture.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  2  run mode: 0 NORMAL, 1 AUTO, 2 SINGLE, 3 treated as NORMAL.
- run  in  1  acquisition enabled level.
- single_req  in  1  one-cycle pulse; re-arms in SINGLE mode.
- div_sel  in  DIV_W  sample strobe every div_sel+1 clocks.
- holdoff  in  HOLDOFF_W  idle clocks after each presented frame.
- trig_seen  in  1  datapath trigger condition met (level pulse).
- capture_done  in  1  datapath has stored a full record (pulse).
- frame_ack  in  1  display consumed the frame.
- sample_en  out  1  one-cycle sample strobe to the datapath.
- arm  out  1  datapath is allowed to detect a trigger and capture.
- force_trig  out  1  one-cycle forced trigger (AUTO timeout).
- frame_valid  out  1  frame ready for the display.
- busy  out  1  high in any state other than IDLE.
- state  out  3  current state encoding, for debug.
- frame_cnt  out  16  number of acknowledged frames; wraps.

## Operation
- States and encodings: IDLE=0, ARMED=1, CAPTURE=2, PRESENT=3, HOLDOFF=4.
- Prescaler
  - Counter runs in all states. When it is at or above div_sel: counter goes to 0 and sample_en pulses.
  - div_sel=0 gives sample_en every cycle.
  - A changed div_sel takes effect on the next compare; the counter never stalls.
- IDLE
  - Enter ARMED when run is high and either mode≠SINGLE or single_req is high.
- ARMED
  - arm=1.
  - trig_seen moves to CAPTURE.
  - AUTO timeout: in AUTO mode, a sample_en timeout counter counts strobes. When it reaches AUTO_TIMEOUT without trig_seen: pulse force_trig and move to CAPTURE.
  - The timeout counter clears on entry to ARMED.
- CAPTURE
  - arm=1.
  - capture_done moves to PRESENT.
- PRESENT
  - frame_valid=1 and held until frame_ack is sampled high.
  - On frame_ack: frame_cnt+1, then go to HOLDOFF. If holdoff=0, go straight to the post-holdoff target.
- HOLDOFF
  - Counts holdoff clocks.
  - Then: in SINGLE mode go to IDLE; otherwise go to ARMED.
- run low
  - From ARMED, CAPTURE or HOLDOFF: go to IDLE next cycle; arm drops; any partial capture is discarded.
  - PRESENT always completes its handshake, then goes to IDLE if run is still low.
- Simultaneous events
  - trig_seen with timeout: trig_seen wins, no force_trig.
  - run low with capture_done: abort wins.
  - single_req outside IDLE: ignored.
  - mode change: takes effect at the next ARMED entry; mode is sampled continuously only in IDLE/ARMED.
- Arithmetic
  - Counters are unsigned and compare with ≥.
  - frame_cnt wraps 0xFFFF→0.

## Timing
- Reset values: every output is 0, state=IDLE, all counters 0.
- All outputs are registered; a state change is visible one cycle after the causing input is sampled.
- force_trig is high for exactly one cycle, coincident with the entry to CAPTURE.
- frame_valid deasserts the cycle after frame_ack is sampled.
- frame_ack is ignored outside PRESENT.
- Holdoff of N clocks: ARMED is entered N+1 cycles after the frame_ack sample.
- Reset asserted mid-operation: outputs clear immediately (asynchronously), and the block restarts in IDLE.

## Configuration
- ACQ_CTRL_AUTO_EN
  - Defined: AUTO mode, the timeout counter and force_trig are present.
  - Undefined: mode 1 behaves as NORMAL, force_trig is tied to 0, and the timeout counter is not built.

## Test plan
- **Reset, then NORMAL:** rst_n low mid-CAPTURE → all outputs 0 immediately. Release, run=1, mode=0 → ARMED one cycle later with arm=1.
- **Prescaler:** div_sel=3 → sample_en every 4 clocks. Switch to div_sel=0 → sample_en every clock with no gap longer than 4.
- **Full NORMAL frame:** trig_seen, then capture_done, then frame_ack two cycles later, with holdoff=10 → frame_valid held until ack, frame_cnt=1, ARMED 11 cycles after the ack sample.
- **AUTO timeout:** AUTO_TIMEOUT=8, div_sel=0, no trigger → force_trig pulses exactly once, 8 strobes after ARMED entry. Same setup with trig_seen on the 8th strobe → no force_trig.
- **SINGLE mode:** one frame completes, then IDLE. A second frame requires single_req. single_req during CAPTURE is ignored.
- **Abort:** run dropped in ARMED → IDLE, arm=0, frame_cnt unchanged. run dropped in PRESENT → frame_valid stays until frame_ack, then IDLE.
